// File: rtl/controlador_contador_gray_pkg.sv
// Shared definitions for the Gray-counter sequencer: state encoding and
// Gray/binary conversion helpers. The helpers work on a wide vector so any
// counter width up to MAXW can use them after zero-extension.
package controlador_contador_gray_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIN   = 2'd2,
    ERROR = 2'd3
  } estado_t;

  // Gray -> binary: b[msb] = g[msb], b[i] = b[i+1] ^ g[i].
  // Zero upper bits in g leave the lower result unaffected.
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary -> Gray: g = b ^ (b >> 1).
  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/controlador_contador_gray_if.sv
// Control/monitor bundle between the stimulus side (master) and the
// sequencer (slave). salida_gray is driven by the counter, which lives on
// the master side of this bundle.
//
// Handshake: start is a level request sampled on posedge clk. It is accepted
// only when the sequencer is idle (ocupado=0, error=0); acceptance is visible
// as ocupado rising on the next cycle. A request seen while busy or in error
// is dropped, never queued. listo pulses for one cycle at the end of each
// accepted run.
interface controlador_contador_gray_if
  import controlador_contador_gray_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic             pausa;
  logic [WIDTH-1:0] longitud;
  logic             clr_error;
  logic [WIDTH-1:0] salida_gray;

  logic             enable;
  logic             ocupado;
  logic             listo;
  logic             error;
  logic [WIDTH-1:0] cuenta_bin;
  estado_t          estado_dbg;

  modport master (
    output start, pausa, longitud, clr_error, salida_gray,
    input  enable, ocupado, listo, error, cuenta_bin, estado_dbg
  );

  modport slave (
    input  start, pausa, longitud, clr_error, salida_gray,
    output enable, ocupado, listo, error, cuenta_bin, estado_dbg
  );

endinterface

// File: rtl/conv_gray_bin.sv
// Combinational Gray -> binary converter of WIDTH bits.
module conv_gray_bin
  import controlador_contador_gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray2bin(MAXW'(gray_i)));

endmodule

// File: rtl/controlador_contador_gray.sv
// Sequencer and monitor for a WIDTH-bit Gray counter.
// A run request loads a length (0 = one full wrap of 2^WIDTH codes) and the
// block then raises the counter enable for exactly that many cycles, holding
// it low while pausa is set. Every cycle outside ERROR the counter output is
// compared against what the previous value and previous enable imply; any
// disagreement forces the ERROR state until clr_error.
module controlador_contador_gray
  import controlador_contador_gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  controlador_contador_gray_if.slave   bus
);

  estado_t          estado_q, estado_d;
  logic [WIDTH:0]   restante_q, restante_d;
  logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic             en_prev_q, en_prev_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] cuenta_bin;
  logic [WIDTH-1:0] bin_prev;
  logic [WIDTH-1:0] bin_prev_inc;
  logic [WIDTH-1:0] gray_exp;
  logic             enable_c;
  logic             fallo;
  logic [WIDTH:0]   carga;

  // Binary view of the live counter value, exported as cuenta_bin.
  conv_gray_bin #(.WIDTH(WIDTH)) u_conv_salida (
    .gray_i (bus.salida_gray),
    .bin_o  (cuenta_bin)
  );

  // Binary view of last cycle's counter value, basis of the expected successor.
  conv_gray_bin #(.WIDTH(WIDTH)) u_conv_prev (
    .gray_i (gray_prev_q),
    .bin_o  (bin_prev)
  );

  // Enable follows the state directly so a pause takes effect in the same cycle.
  assign enable_c = (estado_q == RUN) & ~bus.pausa;

  // Expected counter value and mismatch detection.
  always_comb begin
    bin_prev_inc = bin_prev + WIDTH'(1);
    gray_exp     = WIDTH'(bin2gray(MAXW'(bin_prev_inc)));
    fallo        = 1'b0;
    if (en_prev_q) begin
      fallo = (bus.salida_gray != gray_exp);
    end else begin
      fallo = (bus.salida_gray != gray_prev_q);
    end
  end

  // Run length to load: zero requests a full wrap of 2^WIDTH counts.
  always_comb begin
    carga = {1'b0, bus.longitud};
    if (bus.longitud == '0) begin
      carga = {1'b1, {WIDTH{1'b0}}};
    end
  end

  // Next-state and next-output logic; a checker mismatch overrides every
  // other transition, including start acceptance and FIN -> IDLE.
  always_comb begin
    estado_d    = estado_q;
    restante_d  = restante_q;
    gray_prev_d = bus.salida_gray;
    en_prev_d   = enable_c;

    case (estado_q)
      IDLE: begin
        if (bus.start) begin
          estado_d   = RUN;
          restante_d = carga;
        end
      end
      RUN: begin
        if (enable_c) begin
          restante_d = restante_q - (WIDTH+1)'(1);
          if (restante_q == (WIDTH+1)'(1)) begin
            estado_d = FIN;
          end
        end
      end
      FIN: begin
        estado_d = IDLE;
      end
      ERROR: begin
        if (bus.clr_error) begin
          estado_d = IDLE;
        end
      end
      default: begin
        estado_d = IDLE;
      end
    endcase

    if ((estado_q != ERROR) && fallo) begin
      estado_d   = ERROR;
      restante_d = '0;
    end

    ocupado_d = (estado_d == RUN) || (estado_d == FIN);
    listo_d   = (estado_d == FIN);
    error_d   = (estado_d == ERROR);
  end

  // State, run counter, checker history and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q    <= IDLE;
      restante_q  <= '0;
      gray_prev_q <= '0;
      en_prev_q   <= 1'b0;
      ocupado_q   <= 1'b0;
      listo_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      restante_q  <= restante_d;
      gray_prev_q <= gray_prev_d;
      en_prev_q   <= en_prev_d;
      ocupado_q   <= ocupado_d;
      listo_q     <= listo_d;
      error_q     <= error_d;
    end
  end

  assign bus.enable     = enable_c;
  assign bus.ocupado    = ocupado_q;
  assign bus.listo      = listo_q;
  assign bus.error      = error_q;
  assign bus.cuenta_bin = cuenta_bin;
  assign bus.estado_dbg = estado_q;

endmodule
